// File: rtl/common.sv
// common: shared data-bus request/response types for the core's load/store path.
package common;
    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [63:0] data;
        logic [7:0]  strobe;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

// File: rtl/dbus_responder_pkg.sv
// dbus_responder_pkg: FSM states and access-checking helpers for the data-bus responder.
package dbus_responder_pkg;
    import common::*;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
    function automatic logic misaligned(input logic [2:0] addr, input msize_t size);
        return size == MSIZE2 ? addr[0] :
               size == MSIZE4 ? |addr[1:0] :
               size == MSIZE8 ? |addr[2:0] : 1'b0;
    endfunction
    // Offset compare avoids overflow of base + 8*depth near the top of the address space.
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] depth);
        return addr >= base && (addr - base) < (depth << 3);
    endfunction
    function automatic logic [63:0] strobe_merge(input logic [63:0] old_word, input logic [63:0] new_word,
                                                 input logic [7:0] strobe);
        logic [63:0] w;
        w = old_word;
        for (int b = 0; b < 8; b++)
            if (strobe[b]) w[8*b +: 8] = new_word[8*b +: 8];
        return w;
    endfunction
endpackage

// File: rtl/dbus_sram.sv
// dbus_sram: 1RW DEPTHx64 RAM with per-byte write enable and a registered, clearable read port.
module dbus_sram
    import dbus_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic          clr,
    input  logic [7:0]    we,
    input  logic [63:0]   wdata,
    output logic [63:0]   q
);
    logic [63:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (|we) mem[addr] <= strobe_merge(mem[addr], wdata, we);
    end
    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset) q <= '0;
        else if (clr) q <= '0;
        else if (re) q <= mem[addr];
    end
endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: fixed-latency data-bus responder backed by an internal byte-writable RAM.
module dbus_responder
    import common::*;
    import dbus_responder_pkg::*;
#(
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       fault
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    resp_state_t state;
    logic [3:0]  cnt;
    logic [63:0] addr_q, data_q, rdata;
    logic [7:0]  strobe_q;
    logic        bad_q, accept, bad_in, rd_go, clr, wr_go;
    logic [AW-1:0] idx;
    assign accept = reset && state == IDLE && dreq.valid;
    assign bad_in = misaligned(dreq.addr[2:0], dreq.size) || !in_range(dreq.addr, BASE, 64'(DEPTH));
    assign idx    = AW'(((state == IDLE ? dreq.addr : addr_q) - BASE) >> 3);
    // The read register loads on the edge entering RESP; with LATENCY 1 that is the accept edge.
    assign rd_go  = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    assign clr    = rd_go && (state == IDLE ? bad_in : bad_q);
    assign wr_go  = reset && state == RESP && |strobe_q && !bad_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            bad_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dreq.valid) begin
                    state    <= LATENCY == 1 ? RESP : WAIT;
                    cnt      <= LAT_M1;
                    addr_q   <= dreq.addr;
                    data_q   <= dreq.data;
                    strobe_q <= dreq.strobe;
                    bad_q    <= bad_in;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= cnt == 4'd1 ? RESP : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
    dbus_sram #(.DEPTH(DEPTH)) u_sram (
        .clk  (clk),
        .reset(reset),
        .addr (idx),
        .re   (rd_go),
        .clr  (clr),
        .we   (wr_go ? strobe_q : 8'h00),
        .wdata(data_q),
        .q    (rdata)
    );
    assign dresp.addr_ok = accept;
    assign dresp.data_ok = reset && state == RESP;
    assign dresp.data    = rdata;
    assign fault         = reset && state == RESP && bad_q;
endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: randomized and directed checks of dbus_responder at LATENCY 2, 1 and 7.
module tb_dbus_responder;
    import common::*;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 64;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    dbus_req_t   dreq  [3];
    dbus_resp_t  dresp [3];
    logic        fault [3];
    logic [63:0] mem_m [3][DEPTH];
    int checks = 0;
    int errors = 0;
    bit seen_ok;
    function automatic int lat_of(input int k);
        return k == 0 ? 2 : k == 1 ? 1 : 7;
    endfunction
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            dbus_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(g == 0 ? 2 : g == 1 ? 1 : 7)) u_dut (
                .clk  (clk),
                .reset(reset),
                .dreq (dreq[g]),
                .dresp(dresp[g]),
                .fault(fault[g])
            );
        end
    endgenerate
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic int size_bytes(input msize_t s);
        return s == MSIZE1 ? 1 : s == MSIZE2 ? 2 : s == MSIZE4 ? 4 : 8;
    endfunction
    function automatic bit exp_fault(input logic [63:0] a, input msize_t s);
        return (a % 64'(size_bytes(s))) != 0 || a < BASE || a >= BASE + 64'(8 * DEPTH);
    endfunction
    task automatic check_quiet(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_addr_ok"}, dresp[k].addr_ok, 0);
            check({tag, "_data_ok"}, dresp[k].data_ok, 0);
            check({tag, "_fault"}, fault[k], 0);
            check({tag, "_data"}, dresp[k].data, 0);
        end
    endtask
    task automatic txn(input int k, input logic [63:0] a, input msize_t s, input logic [63:0] d,
                       input logic [7:0] st, input bit drop);
        bit f, seen;
        int idx;
        logic [63:0] exp_d;
        f = exp_fault(a, s);
        idx = f ? 0 : int'((a - BASE) / 8);
        exp_d = f ? 64'h0 : mem_m[k][idx];
        @(negedge clk);
        dreq[k] = '{valid: 1'b1, addr: a, size: s, data: d, strobe: st};
        #1 check("addr_ok", dresp[k].addr_ok, 1);
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (drop && c == 1) begin
                dreq[k].valid  = 1'b0;
                dreq[k].addr   = {$urandom, $urandom};
                dreq[k].data   = {$urandom, $urandom};
                dreq[k].strobe = 8'($urandom);
            end
            if (dresp[k].data_ok) begin
                seen = 1;
                check("latency", 64'(c), 64'(lat_of(k)));
                check("fault", fault[k], f);
                if (f || st == 0) check("rdata", dresp[k].data, exp_d);
            end
        end
        if (!seen) check("data_ok_timeout", 0, 1);
        dreq[k].valid = 1'b0;
        if (!f)
            for (int b = 0; b < 8; b++)
                if (st[b]) mem_m[k][idx][8*b +: 8] = d[8*b +: 8];
    endtask
    task automatic random_txn(input int k);
        logic [63:0] a;
        msize_t s;
        logic [7:0] st;
        s = msize_t'($urandom_range(0, 3));
        a = $urandom_range(0, 9) == 0 ? BASE - 64'($urandom_range(1, 16))
                                      : BASE + 64'($urandom_range(0, 8 * DEPTH + 15));
        if ($urandom_range(0, 9) < 7) a = a & ~64'(size_bytes(s) - 1);
        st = $urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        txn(k, a, s, {$urandom, $urandom}, st, $urandom_range(0, 3) == 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int k = 0; k < 3; k++) dreq[k] = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_quiet("idle");
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < DEPTH; w++)
                txn(k, BASE + 64'(8 * w), MSIZE8, {$urandom, $urandom}, 8'hFF, 0);
            txn(k, 64'h8000_0010, MSIZE8, 64'h1122_3344_5566_7788, 8'hFF, 0);
            txn(k, 64'h8000_0010, MSIZE8, 64'h0, 8'h00, 0);
            txn(k, 64'h8000_0013, MSIZE1, 64'hAB << 24, 8'h08, 0);
            txn(k, 64'h8000_0010, MSIZE8, 64'h0, 8'h00, 0);
            check("partial_model", mem_m[k][2], 64'h1122_3344_AB66_7788);
            txn(k, 64'h8000_0004, MSIZE8, 64'h0, 8'h00, 0);
            txn(k, BASE + 64'(8 * DEPTH), MSIZE8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0);
            txn(k, BASE, MSIZE8, 64'h0, 8'h00, 0);
            if (lat_of(k) > 1) begin
                @(negedge clk);
                dreq[k] = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, data: 64'hCAFE_F00D_CAFE_F00D, strobe: 8'hFF};
                #1 check("abort_addr_ok", dresp[k].addr_ok, 1);
                @(negedge clk);
                reset = 1'b0;
                dreq[k].valid = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                seen_ok = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (dresp[k].data_ok) seen_ok = 1;
                end
                check("abort_no_data_ok", seen_ok, 0);
                txn(k, 64'h8000_0010, MSIZE8, 64'h0, 8'h00, 0);
            end
            repeat (40) random_txn(k);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
